// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 capture path: pixel bundles, row geometry and the
// capture FSM states.
package hub75_pkg;

    localparam int HUB75_ROWS_HALF = 16;
    localparam int ROW_W           = $clog2(HUB75_ROWS_HALF);

    typedef logic [2:0] rgb3_t;

    typedef struct packed {
        rgb3_t top;
        rgb3_t bot;
    } pix6_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } cap_state_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector for one HUB75 control
// line. The rise output is combinational from the last sync stage and a history flop.
module hub75_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A line already high at reset release shows up as a rising edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 sink: oversamples the panel signals, shifts pixels on clk_shft, commits a row on
// LAT and replays it as a ready/valid pixel stream. Optional err_oe via HUB75_CAP_OE_CHECK_EN.
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int COLS        = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     A,
    input  logic                     B,
    input  logic                     C,
    input  logic                     D,
    input  logic                     R0,
    input  logic                     G0,
    input  logic                     B0,
    input  logic                     R1,
    input  logic                     G1,
    input  logic                     B1,
    input  logic                     clk_shft,
    input  logic                     LAT,
    input  logic                     OE,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [3:0]               px_row,
    output logic [$clog2(COLS)-1:0]  px_col,
    output logic [2:0]               px_top,
    output logic [2:0]               px_bot,
    output logic                     frame_sync,
    output logic                     err_len,
    output logic                     err_ovf
`ifdef HUB75_CAP_OE_CHECK_EN
    ,
    output logic                     err_oe
`endif
);

    localparam int COL_W  = $clog2(COLS);
    localparam int CNT_W  = $clog2(COLS + 2);
    localparam int DATA_W = ROW_W + 7;

    logic shft_rise;
    logic lat_rise;

    hub75_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shft (
        .clk  (clk),
        .rst  (rst),
        .din  (clk_shft),
        .rise (shft_rise)
    );

    hub75_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
        .clk  (clk),
        .rst  (rst),
        .din  (LAT),
        .rise (lat_rise)
    );

    // Data/address use the same depth as the strobes so they line up with the edge.
    logic [SYNC_STAGES-1:0][DATA_W-1:0] dsync_q;
    logic [DATA_W-1:0]                  dsync;
    logic [ROW_W-1:0]                   row_s;
    logic                               oe_s;
    pix6_t                              pix_in;

    assign dsync  = dsync_q[SYNC_STAGES-1];
    assign row_s  = dsync[DATA_W-1 -: ROW_W];
    assign oe_s   = dsync[6];
    assign pix_in = pix6_t'(dsync[5:0]);

    cap_state_t            state_q, state_d;
    pix6_t [COLS-1:0]      shift_q, shift_next;
    pix6_t [COLS-1:0]      line_q;
    logic [CNT_W-1:0]      bit_cnt, cnt_next;
    logic [ROW_W-1:0]      prev_row;
    logic                  latch_accept;
    logic                  beat;
    logic                  last_beat;

    assign px_valid     = (state_q == STREAM);
    assign beat         = px_valid & px_ready;
    assign last_beat    = beat && (px_col == COL_W'(COLS - 1));
    assign latch_accept = lat_rise && (state_q == IDLE);
    assign px_top       = line_q[px_col].top;
    assign px_bot       = line_q[px_col].bot;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shift_next = shift_q;
        cnt_next   = bit_cnt;
        if (shft_rise) begin
            shift_next = {shift_q[COLS-2:0], pix_in};
            if (bit_cnt != CNT_W'(COLS + 1)) begin
                cnt_next = bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (latch_accept) state_d = STREAM;
            STREAM:  if (last_beat)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the line buffer is reset along with everything else because px_top/px_bot
    // read it combinationally and must be 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsync_q    <= '0;
            shift_q    <= '0;
            line_q     <= '0;
            bit_cnt    <= '0;
            prev_row   <= '0;
            px_row     <= '0;
            px_col     <= '0;
            frame_sync <= 1'b0;
            err_len    <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            dsync_q    <= {dsync_q[SYNC_STAGES-2:0],
                           {D, C, B, A, OE, R0, G0, B0, R1, G1, B1}};
            shift_q    <= shift_next;
            bit_cnt    <= lat_rise ? '0 : cnt_next;
            frame_sync <= 1'b0;
            err_len    <= 1'b0;
            err_ovf    <= 1'b0;
            if (latch_accept) begin
                line_q     <= shift_next;
                px_row     <= row_s;
                px_col     <= '0;
                err_len    <= (cnt_next != CNT_W'(COLS));
                frame_sync <= (row_s < prev_row);
                prev_row   <= row_s;
            end else if (lat_rise) begin
                err_ovf <= 1'b1;
            end
            if (beat) begin
                px_col <= last_beat ? '0 : px_col + 1'b1;
            end
        end
    end

`ifdef HUB75_CAP_OE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err_oe <= 1'b0;
        else     err_oe <= lat_rise & ~oe_s;
    end
`else
    logic unused_oe;
    assign unused_oe = oe_s;
`endif

endmodule
